// File: rtl/tpram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// tpram_fifo_pkg
// Shared constants for the two-port-RAM streaming FIFO.
//   DW    : beat width, equal to the RAM word width
//   AW    : RAM address width
//   DEPTH : RAM entries (2**AW)
//   CW    : width of the occupancy count (0..DEPTH+2)
// -----------------------------------------------------------------------------
package tpram_fifo_pkg;

    localparam int DW    = 144;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int CW    = AW + 2;

endpackage : tpram_fifo_pkg

// File: rtl/tpram_fifo_outbuf.sv
// -----------------------------------------------------------------------------
// tpram_fifo_outbuf
// Two-entry output buffer with a registered head. Absorbs the RAM read latency
// so the consumer sees a plain valid/ready stream. Push and pop may happen in
// the same cycle at any occupancy; the caller never pushes into a full buffer
// without popping in that cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous flush, empties the buffer
//   push        : load push_data this cycle
//   push_data   : beat to store
//   pop         : consumer takes the head this cycle
//   head_data   : registered head beat
//   ob_cnt      : number of beats held (0..2)
// -----------------------------------------------------------------------------
module tpram_fifo_outbuf #(
    parameter int DW = tpram_fifo_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [1:0]    ob_cnt
);

    import tpram_fifo_pkg::*;

    logic [DW-1:0] head_r;
    logic [DW-1:0] tail_r;
    logic [1:0]    cnt_r;

    logic [DW-1:0] head_nxt_s;
    logic [DW-1:0] tail_nxt_s;
    logic [1:0]    cnt_nxt_s;

    // Next-state of the two slots and the occupancy.
    always_comb begin
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        cnt_nxt_s  = cnt_r;
        if (clr) begin
            head_nxt_s = {DW{1'b0}};
            cnt_nxt_s  = 2'd0;
        end else begin
            case (cnt_r)
                2'd0: begin
                    if (push) begin
                        head_nxt_s = push_data;
                        cnt_nxt_s  = 2'd1;
                    end else begin
                        cnt_nxt_s = 2'd0;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        // head leaves, new beat becomes head directly
                        head_nxt_s = push_data;
                    end else if (push) begin
                        tail_nxt_s = push_data;
                        cnt_nxt_s  = 2'd2;
                    end else if (pop) begin
                        cnt_nxt_s = 2'd0;
                    end else begin
                        cnt_nxt_s = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_nxt_s = tail_r;
                        if (push) begin
                            tail_nxt_s = push_data;
                        end else begin
                            cnt_nxt_s = 2'd1;
                        end
                    end else begin
                        cnt_nxt_s = 2'd2;
                    end
                end
                default: begin
                    cnt_nxt_s = 2'd0;
                end
            endcase
        end
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= {DW{1'b0}};
            tail_r <= {DW{1'b0}};
            cnt_r  <= 2'd0;
        end else begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign head_data = head_r;
    assign ob_cnt    = cnt_r;

endmodule : tpram_fifo_outbuf

// File: rtl/tpram_stream_fifo.sv
// -----------------------------------------------------------------------------
// tpram_stream_fifo
// Valid/ready streaming FIFO built around an external two-port RAM macro
// (DEPTH x DW, both RAM clocks tied to clk). The write port is driven
// combinationally from the producer handshake; reads are issued ahead so the
// one-cycle RAM read latency is hidden by a two-entry output buffer.
// Optional build macro TPRAM_STREAM_FIFO_BYPASS_EN: when the RAM and the read
// pipeline are empty, an accepted beat goes straight into the output buffer
// (visible the cycle after the handshake) and the RAM is not written.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   clr                  : synchronous flush
//   wr_valid/ready/data  : producer side
//   rd_valid/ready/data  : consumer side (rd_data registered)
//   count                : beats held in RAM + read in flight + output buffer
//   ram_wceb/waddr/wdata : RAM write port (enable active-low)
//   ram_rceb/raddr       : RAM read port (enable active-low)
//   ram_rdata            : RAM read data, valid the cycle after a read issue
// -----------------------------------------------------------------------------
module tpram_stream_fifo #(
    parameter int DW    = tpram_fifo_pkg::DW,
    parameter int AW    = tpram_fifo_pkg::AW,
    parameter int DEPTH = tpram_fifo_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW+1:0] count,
    output logic          ram_wceb,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_rceb,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata
);

    import tpram_fifo_pkg::*;

    localparam int          CNT_W    = AW + 2;
    localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic             inflight_r;
    logic [CNT_W-1:0] count_r;

    logic [AW:0]      ram_cnt_s;
    logic             full_s;
    logic             ram_empty_s;
    logic             wr_ready_s;
    logic             wr_fire_s;
    logic             wr_ram_s;
    logic             byp_s;
    logic             pop_s;
    logic [2:0]       occ_s;
    logic             issue_s;
    logic             rd_valid_s;
    logic [1:0]       ob_cnt_s;
    logic             ob_push_s;
    logic [DW-1:0]    ob_push_data_s;
    logic [DW-1:0]    ob_head_s;

    // Handshake, read-issue and bypass decisions for the current cycle.
    always_comb begin
        ram_cnt_s   = wptr_r - rptr_r;
        full_s      = (ram_cnt_s == DEPTH_V);
        ram_empty_s = (ram_cnt_s == PTR_ZERO);
        // A read issued this cycle gives no credit to the writer: full stays full.
        wr_ready_s  = !full_s && !clr;
        wr_fire_s   = wr_valid && wr_ready_s;
        pop_s       = rd_valid_s && rd_ready;
        // Output-buffer occupancy after this cycle, counting the read in flight.
        occ_s       = {1'b0, ob_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        // ram_cnt ignores this cycle's write, so a fresh entry is never read
        // in the same cycle it is written.
        issue_s     = !ram_empty_s && !clr && (occ_s < 3'd2);
`ifdef TPRAM_STREAM_FIFO_BYPASS_EN
        // Only safe when nothing older sits in the RAM or the read pipeline.
        byp_s       = wr_fire_s && ram_empty_s && !inflight_r &&
                      ((ob_cnt_s != 2'd2) || pop_s);
`else
        byp_s       = 1'b0;
`endif
        wr_ram_s    = wr_fire_s && !byp_s;
        // Capture and bypass are exclusive: bypass requires no read in flight.
        ob_push_s   = (inflight_r || byp_s) && !clr;
        if (inflight_r) begin
            ob_push_data_s = ram_rdata;
        end else begin
            ob_push_data_s = wr_data;
        end
    end

    // Pointer, in-flight flag and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r     <= PTR_ZERO;
            rptr_r     <= PTR_ZERO;
            inflight_r <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
        end else if (clr) begin
            wptr_r     <= PTR_ZERO;
            rptr_r     <= PTR_ZERO;
            inflight_r <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
        end else begin
            if (wr_ram_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (issue_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            inflight_r <= issue_s;
            // Beats only move between RAM, pipeline and buffer internally, so
            // the total changes by accepted writes minus pops.
            count_r    <= count_r + {{(CNT_W-1){1'b0}}, wr_fire_s}
                                  - {{(CNT_W-1){1'b0}}, pop_s};
        end
    end

    tpram_fifo_outbuf #(
        .DW (DW)
    ) u_outbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (ob_push_s),
        .push_data (ob_push_data_s),
        .pop       (pop_s),
        .head_data (ob_head_s),
        .ob_cnt    (ob_cnt_s)
    );

    assign rd_valid_s = (ob_cnt_s != 2'd0);

    assign wr_ready  = wr_ready_s;
    assign rd_valid  = rd_valid_s;
    assign rd_data   = ob_head_s;
    assign count     = count_r;
    assign ram_wceb  = !wr_ram_s;
    assign ram_waddr = wptr_r[AW-1:0];
    assign ram_wdata = wr_data;
    assign ram_rceb  = !issue_s;
    assign ram_raddr = rptr_r[AW-1:0];

endmodule : tpram_stream_fifo

// File: tb/tb_tpram_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_tpram_stream_fifo
// Self-checking bench for tpram_stream_fifo with a behavioural two-port RAM.
// Inputs change 1 time unit after the rising edge; outputs are observed on the
// falling edge. Accepted beats are queued and compared when popped.
// -----------------------------------------------------------------------------
module tb_tpram_stream_fifo;

    localparam int DW    = 144;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int CW    = AW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;
    logic          ram_wceb;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_rceb;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] sb_q [$];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    // Two-port RAM macro model: synchronous write, one-cycle read.
    always @(posedge clk) begin
        if (!ram_wceb) mem[ram_waddr] <= ram_wdata;
        if (!ram_rceb) ram_rdata <= mem[ram_raddr];
    end

    tpram_stream_fifo dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count),
        .ram_wceb(ram_wceb), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_rceb(ram_rceb), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    function automatic logic [DW-1:0] rand_beat();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic do_clr();
        @(posedge clk); #1;
        clr = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        checks++; if (count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (ram_wceb !== 1'b1) begin failures++; $display("FAIL reset_ram_wceb got=%b want=1", ram_wceb); end
        checks++; if (ram_rceb !== 1'b1) begin failures++; $display("FAIL reset_ram_rceb got=%b want=1", ram_rceb); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = 144'hA5;
        @(negedge clk);   // cycle n
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL single_wr_ready got=%b want=1", wr_ready); end
`ifdef TPRAM_STREAM_FIFO_BYPASS_EN
        checks++; if (ram_wceb !== 1'b1) begin failures++; $display("FAIL single_byp_wceb got=%b want=1", ram_wceb); end
        @(posedge clk); #1;   // edge n
        wr_valid = 1'b0; rd_ready = 1'b1;
        @(negedge clk);
`else
        checks++; if (ram_wceb !== 1'b0 || ram_waddr !== 6'd0 || ram_wdata !== 144'hA5) begin
            failures++; $display("FAIL single_write got wceb=%b waddr=%0d wdata=%h want 0/0/a5", ram_wceb, ram_waddr, ram_wdata); end
        @(posedge clk); #1;   // edge n
        wr_valid = 1'b0;
        @(negedge clk);       // cycle n+1
        checks++; if (ram_rceb !== 1'b0 || ram_raddr !== 6'd0) begin
            failures++; $display("FAIL single_read_issue got rceb=%b raddr=%0d want 0/0", ram_rceb, ram_raddr); end
        checks++; if (count !== 8'd1) begin failures++; $display("FAIL single_count1 got=%0d want=1", count); end
        @(posedge clk); #1;   // edge n+1
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b want=0", rd_valid); end
        @(posedge clk); #1;   // edge n+2
        rd_ready = 1'b1;
        @(negedge clk);
`endif
        checks++; if (rd_valid !== 1'b1 || rd_data !== 144'hA5) begin
            failures++; $display("FAIL single_out got valid=%b data=%h want 1/a5", rd_valid, rd_data); end
        checks++; if (count !== 8'd1) begin failures++; $display("FAIL single_count_held got=%0d want=1", count); end
        @(posedge clk); #1;
        rd_ready = 1'b0;
        @(negedge clk);
        checks++; if (count !== 8'd0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL single_after_pop got count=%0d valid=%b want 0/0", count, rd_valid); end
    endtask

    task automatic test_fill();
        int accepted = 0;
        bit stalled = 0;
        do_clr();
        for (int cyc = 0; cyc < 200 && !stalled; cyc++) begin
            @(posedge clk); #1;
            wr_valid = 1'b1; rd_ready = 1'b0; wr_data = {16'hF111, 128'(accepted)};
            @(negedge clk);
            if (wr_ready) begin sb_q.push_back(wr_data); accepted++; end
            else stalled = 1;
        end
        checks++; if (accepted != DEPTH + 2) begin failures++; $display("FAIL fill_accepted got=%0d want=%0d", accepted, DEPTH + 2); end
        checks++; if (count !== 8'd66) begin failures++; $display("FAIL fill_count got=%0d want=66", count); end
        checks++; if (ram_rceb !== 1'b1) begin failures++; $display("FAIL fill_rceb got=%b want=1", ram_rceb); end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL fill_rd_valid got=%b want=1", rd_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (wr_ready !== 1'b0 || ram_rceb !== 1'b1) begin
            failures++; $display("FAIL fill_hold got wr_ready=%b rceb=%b want 0/1", wr_ready, ram_rceb); end
        for (int cyc = 0; cyc < 300 && sb_q.size() != 0; cyc++) begin
            @(posedge clk); #1;
            wr_valid = 1'b0; rd_ready = 1'b1;
            @(negedge clk);
            if (rd_valid) begin
                checks++; if (rd_data !== sb_q[0]) begin failures++; $display("FAIL fill_drain_data got=%h want=%h", rd_data, sb_q[0]); end
                void'(sb_q.pop_front());
            end
        end
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL fill_drain_timeout got=%0d left want=0", sb_q.size()); end
        @(posedge clk); #1;
        rd_ready = 1'b0;
        @(negedge clk);
        checks++; if (count !== 8'd0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL fill_empty got count=%0d valid=%b want 0/0", count, rd_valid); end
    endtask

    task automatic test_streaming();
        int sent = 0, got = 0, stalls = 0, first_cyc = -1, last_cyc = -1;
        do_clr();
        for (int cyc = 0; cyc < 600 && got < 200; cyc++) begin
            @(posedge clk); #1;
            wr_valid = (sent < 200); rd_ready = 1'b1; wr_data = {16'hC0DE, 128'(sent)};
            @(negedge clk);
            if (wr_valid && !wr_ready) stalls++;
            if (rd_valid && rd_ready) begin
                checks++;
                if (sb_q.size() == 0) begin failures++; $display("FAIL stream_spurious got=%h want=none", rd_data); end
                else begin
                    if (rd_data !== sb_q[0]) begin failures++; $display("FAIL stream_data got=%h want=%h", rd_data, sb_q[0]); end
                    void'(sb_q.pop_front());
                end
                if (got == 0) first_cyc = cyc;
                got++;
                if (got == 200) last_cyc = cyc;
            end
            if (wr_valid && wr_ready) begin sb_q.push_back(wr_data); sent++; end
        end
        checks++; if (got != 200) begin failures++; $display("FAIL stream_count got=%0d want=200", got); end
        checks++; if (stalls != 0) begin failures++; $display("FAIL stream_wr_stalls got=%0d want=0", stalls); end
        checks++; if (last_cyc - first_cyc != 199) begin failures++; $display("FAIL stream_rate got=%0d cycles want=199", last_cyc - first_cyc); end
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        checks++; if (count !== 8'd0) begin failures++; $display("FAIL stream_final_count got=%0d want=0", count); end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0;
        do_clr();
        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            @(posedge clk); #1;
            wr_valid = (sent < 10000) && 1'($urandom_range(0, 1));
            wr_data  = rand_beat();
            rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (count !== CW'(sb_q.size())) begin failures++; $display("FAIL bp_count got=%0d want=%0d", count, sb_q.size()); end
            if (rd_valid && rd_ready) begin
                checks++;
                if (sb_q.size() == 0) begin failures++; $display("FAIL bp_spurious got=%h want=none", rd_data); end
                else begin
                    if (rd_data !== sb_q[0]) begin failures++; $display("FAIL bp_data got=%h want=%h", rd_data, sb_q[0]); end
                    void'(sb_q.pop_front());
                end
                got++;
            end
            if (wr_valid && wr_ready) begin sb_q.push_back(wr_data); sent++; end
        end
        checks++; if (got != 10000) begin failures++; $display("FAIL bp_timeout got=%0d want=10000", got); end
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_clr();
        int got = 0;
        do_clr();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            wr_valid = 1'b1; rd_ready = 1'b0; wr_data = {16'hBEEF, 128'(i)};
            @(negedge clk);
            if (wr_ready) sb_q.push_back(wr_data);
        end
        repeat (3) begin
            @(posedge clk); #1;
            wr_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (count !== 8'd5) begin failures++; $display("FAIL clr_pre_count got=%0d want=5", count); end
        // pop one and write one: the freed slot triggers a read that is in flight at clr
        @(posedge clk); #1;
        wr_valid = 1'b1; rd_ready = 1'b1; wr_data = {16'hBEEF, 128'(5)};
        @(negedge clk);
        checks++; if (ram_rceb !== 1'b0 || rd_valid !== 1'b1) begin
            failures++; $display("FAIL clr_issue got rceb=%b valid=%b want 0/1", ram_rceb, rd_valid); end
        @(posedge clk); #1;
        clr = 1'b1; wr_valid = 1'b1; rd_ready = 1'b0; wr_data = {DW{1'b1}};
        @(negedge clk);
        checks++; if (count !== 8'd5) begin failures++; $display("FAIL clr_held_count got=%0d want=5", count); end
        checks++; if (wr_ready !== 1'b0 || ram_wceb !== 1'b1 || ram_rceb !== 1'b1) begin
            failures++; $display("FAIL clr_no_access got wr_ready=%b wceb=%b rceb=%b want 0/1/1", wr_ready, ram_wceb, ram_rceb); end
        @(posedge clk); #1;
        clr = 1'b0; wr_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        checks++; if (count !== 8'd0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL clr_after got count=%0d valid=%b want 0/0", count, rd_valid); end
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            wr_valid = (cyc == 0); wr_data = 144'h1; rd_ready = 1'b1;
            @(negedge clk);
            if (rd_valid) begin
                checks++;
                if (sb_q.size() == 0) begin failures++; $display("FAIL clr_stale_beat got=%h want=none", rd_data); end
                else begin
                    if (rd_data !== sb_q[0]) begin failures++; $display("FAIL clr_first_beat got=%h want=%h", rd_data, sb_q[0]); end
                    void'(sb_q.pop_front());
                    got++;
                end
            end
            if (wr_valid && wr_ready) sb_q.push_back(wr_data);
        end
        checks++; if (got != 1) begin failures++; $display("FAIL clr_beats_out got=%0d want=1", got); end
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_clr();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            wr_valid = 1'b1; rd_ready = 1'b0; wr_data = rand_beat();
            @(negedge clk);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 8'd3) begin failures++; $display("FAIL arst_pre_count got=%0d want=3", count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 8'd0 || rd_valid !== 1'b0 || ram_rceb !== 1'b1 || wr_ready !== 1'b1) begin
            failures++; $display("FAIL arst_values got count=%0d valid=%b rceb=%b wr_ready=%b want 0/0/1/1", count, rd_valid, ram_rceb, wr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

`ifdef TPRAM_STREAM_FIFO_BYPASS_EN
    task automatic test_bypass_order();
        int wr_ram_n = 0;
        do_clr();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            wr_valid = 1'b1; rd_ready = 1'b0; wr_data = {16'hB0B0, 128'(i)};
            @(negedge clk);
            if (i < 2) begin
                checks++; if (ram_wceb !== 1'b1) begin failures++; $display("FAIL byp_skip_ram beat=%0d got wceb=%b want=1", i, ram_wceb); end
            end else if (!ram_wceb) wr_ram_n++;
            if (i == 1) begin
                checks++; if (rd_valid !== 1'b1 || rd_data !== {16'hB0B0, 128'(0)}) begin
                    failures++; $display("FAIL byp_latency got valid=%b data=%h want 1/b0b0..0", rd_valid, rd_data); end
            end
            if (wr_ready) sb_q.push_back(wr_data);
        end
        checks++; if (wr_ram_n != 3) begin failures++; $display("FAIL byp_ram_writes got=%0d want=3", wr_ram_n); end
        for (int cyc = 0; cyc < 30 && sb_q.size() != 0; cyc++) begin
            @(posedge clk); #1;
            wr_valid = 1'b0; rd_ready = 1'b1;
            @(negedge clk);
            if (rd_valid) begin
                checks++; if (rd_data !== sb_q[0]) begin failures++; $display("FAIL byp_order got=%h want=%h", rd_data, sb_q[0]); end
                void'(sb_q.pop_front());
            end
        end
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL byp_drain_timeout got=%0d left want=0", sb_q.size()); end
        @(posedge clk); #1;
        rd_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_fill();
        test_streaming();
        test_backpressure();
        test_clr();
        test_async_reset();
`ifdef TPRAM_STREAM_FIFO_BYPASS_EN
        test_bypass_order();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tpram_stream_fifo
